// File: rtl/divisor_16_pkg.sv
// Shared types and sizes for the 32/16 restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package divisor_16_pkg;

   localparam int DIVIDEND_W = 32;
   localparam int DIVISOR_W  = 16;
   localparam int ITER       = 16;
   localparam int CNT_W      = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DIV   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/divisor_16_step.sv
// One restoring-division stage: shift in a dividend bit, trial-subtract, keep or restore.
// Latency: purely combinational.
// Backpressure: none.
module divisor_16_step
   import divisor_16_pkg::*;
(
   input  logic [DIVISOR_W:0]   rem,
   input  logic                 in_bit,
   input  logic [DIVISOR_W-1:0] dvs,
   output logic [DIVISOR_W:0]   rem_nxt,
   output logic                 q_bit
);

   logic [DIVISOR_W+1:0] shifted;
   logic [DIVISOR_W+1:0] diff;

   // The partial remainder is always below the divisor, so after the shift
   // it fits in 17 bits; the extra top bit only keeps the compare exact.
   always_comb begin
      shifted = {rem, in_bit};
      diff    = shifted - {2'b00, dvs};
      q_bit   = (shifted >= {2'b00, dvs});
      rem_nxt = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
   end

endmodule

// File: rtl/divisor_16.sv
// 32/16 sequential restoring divider; DIVISOR_16_SIGNED_EN selects two's-complement operands.
// Latency: Done 18 cycles after the start edge, 2 cycles on divide-by-zero/overflow.
// Backpressure: none; St is only sampled in IDLE, operand changes while busy are ignored.
module divisor_16
   import divisor_16_pkg::*;
(
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  St,
   input  logic [DIVIDEND_W-1:0] Dividendo,
   input  logic [DIVISOR_W-1:0]  Divisor,
   output logic                  Idle,
   output logic                  Done,
   output logic [DIVISOR_W-1:0]  Quociente,
   output logic [DIVISOR_W-1:0]  Resto,
   output logic                  Ovf
);

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [DIVISOR_W:0]   pr;
   logic [DIVISOR_W-1:0] qr;
   logic [DIVISOR_W-1:0] dvs;
   logic                 chk_ovf;
   logic [DIVISOR_W:0]   pr_nxt;
   logic                 q_bit;
   logic [DIVIDEND_W-1:0] a_mag;
   logic [DIVISOR_W-1:0]  b_mag;
   logic [DIVISOR_W-1:0]  res_q;
   logic [DIVISOR_W-1:0]  res_r;
   logic                  res_ovf;

`ifdef DIVISOR_16_SIGNED_EN
   logic neg_q;
   logic neg_r;

   // Divide magnitudes; signs are reapplied when the result is loaded.
   assign a_mag = Dividendo[DIVIDEND_W-1] ? (~Dividendo + 1'b1) : Dividendo;
   assign b_mag = Divisor[DIVISOR_W-1]    ? (~Divisor + 1'b1)   : Divisor;

   // Result formatting: range check on the magnitude quotient, then sign fix-up.
   always_comb begin
      res_ovf = chk_ovf;
      if (!chk_ovf && (neg_q ? (qr > 16'h8000) : (qr > 16'h7FFF)))
         res_ovf = 1'b1;
      res_q = neg_q ? (~qr + 1'b1) : qr;
      res_r = neg_r ? (~pr[DIVISOR_W-1:0] + 1'b1) : pr[DIVISOR_W-1:0];
      if (res_ovf) begin
         res_q = '1;
         res_r = '0;
      end
   end
`else
   assign a_mag = Dividendo;
   assign b_mag = Divisor;

   // Result formatting: overflow forces the saturated quotient and zero remainder.
   always_comb begin
      res_ovf = chk_ovf;
      res_q   = qr;
      res_r   = pr[DIVISOR_W-1:0];
      if (chk_ovf) begin
         res_q = '1;
         res_r = '0;
      end
   end
`endif

   divisor_16_step u_step (
      .rem     (pr),
      .in_bit  (qr[DIVISOR_W-1]),
      .dvs     (dvs),
      .rem_nxt (pr_nxt),
      .q_bit   (q_bit)
   );

   // Control FSM and datapath; the quotient register doubles as the low dividend shifter.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state     <= IDLE;
         cnt       <= '0;
         pr        <= '0;
         qr        <= '0;
         dvs       <= '0;
         chk_ovf   <= 1'b0;
         Idle      <= 1'b1;
         Done      <= 1'b0;
         Quociente <= '0;
         Resto     <= '0;
         Ovf       <= 1'b0;
`ifdef DIVISOR_16_SIGNED_EN
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
`endif
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (St) begin
                  pr    <= {1'b0, a_mag[DIVIDEND_W-1:DIVISOR_W]};
                  qr    <= a_mag[DIVISOR_W-1:0];
                  dvs   <= b_mag;
                  cnt   <= '0;
                  Idle  <= 1'b0;
                  state <= CHECK;
`ifdef DIVISOR_16_SIGNED_EN
                  neg_q <= Dividendo[DIVIDEND_W-1] ^ Divisor[DIVISOR_W-1];
                  neg_r <= Dividendo[DIVIDEND_W-1];
`endif
               end
            end
            CHECK: begin
               // A high half not below the divisor means the quotient needs more than 16 bits.
               if ((dvs == '0) || (pr[DIVISOR_W-1:0] >= dvs)) begin
                  chk_ovf <= 1'b1;
                  state   <= DONE;
               end else begin
                  chk_ovf <= 1'b0;
                  state   <= DIV;
               end
            end
            DIV: begin
               pr <= pr_nxt;
               qr <= {qr[DIVISOR_W-2:0], q_bit};
               if (cnt == CNT_W'(ITER - 1))
                  state <= DONE;
               else
                  cnt <= cnt + 1'b1;
            end
            DONE: begin
               Done      <= 1'b1;
               Quociente <= res_q;
               Resto     <= res_r;
               Ovf       <= res_ovf;
               Idle      <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_16.sv
// Directed bench for divisor_16 with a result scoreboard.
// Latency: checks 18/2-cycle Done timing per operation.
// Backpressure: n/a.
module tb_divisor_16;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        St = 1'b0;
   logic [31:0] Dividendo = '0;
   logic [15:0] Divisor = '0;
   logic        Idle;
   logic        Done;
   logic [15:0] Quociente;
   logic [15:0] Resto;
   logic        Ovf;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        ovf;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int compared = 0;
   int mismatched = 0;

   divisor_16 dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .St        (St),
      .Dividendo (Dividendo),
      .Divisor   (Divisor),
      .Idle      (Idle),
      .Done      (Done),
      .Quociente (Quociente),
      .Resto     (Resto),
      .Ovf       (Ovf)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
      exp_t e;
`ifdef DIVISOR_16_SIGNED_EN
      logic [31:0] ma;
      logic [15:0] mb;
      logic [31:0] mq;
      logic [31:0] mr;
      logic        neg;
      ma  = a[31] ? (~a + 32'd1) : a;
      mb  = b[15] ? (~b + 16'd1) : b;
      neg = a[31] ^ b[15];
      if (mb == 16'd0 || ma[31:16] >= mb) begin
         e.q = 16'hFFFF; e.r = 16'h0; e.ovf = 1'b1; e.lat = 2;
      end else begin
         mq = ma / {16'd0, mb};
         mr = ma % {16'd0, mb};
         e.lat = 18;
         if (neg ? (mq > 32'h8000) : (mq > 32'h7FFF)) begin
            e.q = 16'hFFFF; e.r = 16'h0; e.ovf = 1'b1;
         end else begin
            e.q   = neg ? (~mq[15:0] + 16'd1) : mq[15:0];
            e.r   = a[31] ? (~mr[15:0] + 16'd1) : mr[15:0];
            e.ovf = 1'b0;
         end
      end
`else
      logic [31:0] fq;
      logic [31:0] fr;
      if (b == 16'd0 || a[31:16] >= b) begin
         e.q = 16'hFFFF; e.r = 16'h0; e.ovf = 1'b1; e.lat = 2;
      end else begin
         fq = a / {16'd0, b};
         fr = a % {16'd0, b};
         e.q = fq[15:0]; e.r = fr[15:0]; e.ovf = 1'b0; e.lat = 18;
      end
`endif
      return e;
   endfunction

   // Present operands with St high and record the expected result.
   task automatic drive(input logic [31:0] a, input logic [15:0] b);
      sb.push_back(model(a, b));
      St = 1'b1;
      Dividendo = a;
      Divisor = b;
   endtask

   // Called #1 after the start edge: scramble inputs, wait for Done, compare against scoreboard.
   task automatic wait_result(input string tag, input logic [31:0] a, input logic [15:0] b);
      exp_t e;
      int lat;
      bit seen;
      logic [31:0] chk;
      lat = 0;
      seen = 1'b0;
      Dividendo = $urandom;
      Divisor = 16'($urandom);
      while (lat < 30 && !seen) begin
         if (Done === 1'b1) seen = 1'b1;
         else begin
            if (lat == 1) begin
               St = 1'b0;
               check({tag, " busy_idle"}, 32'(Idle), 32'd0);
            end
            @(posedge Clk); #1;
            lat++;
         end
      end
      St = 1'b0;
      e = sb.pop_front();
      check({tag, " done_seen"}, 32'(seen), 32'd1);
      check({tag, " latency"}, lat, e.lat);
      check({tag, " quociente"}, 32'(Quociente), 32'(e.q));
      check({tag, " resto"}, 32'(Resto), 32'(e.r));
      check({tag, " ovf"}, 32'(Ovf), 32'(e.ovf));
      check({tag, " idle_at_done"}, 32'(Idle), 32'd1);
`ifndef DIVISOR_16_SIGNED_EN
      if (seen && !e.ovf) begin
         chk = {16'd0, Quociente} * {16'd0, b} + {16'd0, Resto};
         check({tag, " identity"}, chk, a);
         check({tag, " resto_lt_divisor"}, 32'(Resto < b), 32'd1);
      end
`endif
      @(posedge Clk); #1;
      check({tag, " done_one_cycle"}, 32'(Done), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b);
      drive(a, b);
      @(posedge Clk); #1;
      wait_result(tag, a, b);
   endtask

   initial begin
      int pulses;
      int first_idx;
      int second_idx;
      int dcount;
      bit seen3;
      logic [15:0] rb;
      logic [15:0] rh;
      exp_t e143;

      // Asynchronous reset assertion with no clock edge involved.
      #2 Rst = 1'b0;
      #1;
      check("rst idle", 32'(Idle), 32'd1);
      check("rst done", 32'(Done), 32'd0);
      check("rst quociente", 32'(Quociente), 32'd0);
      check("rst resto", 32'(Resto), 32'd0);
      check("rst ovf", 32'(Ovf), 32'd0);

      // St already high at reset release: the first edge after release starts the operation.
      drive(32'd143, 16'd11);
      #20 Rst = 1'b1;
      @(posedge Clk); #1;
      wait_result("143/11", 32'd143, 16'd11);

      run_op("8006001/4001", 32'd8006001, 16'd4001);
      run_op("8006002/4001", 32'd8006002, 16'd4001);
      run_op("fffe0001/ffff", 32'hFFFE0001, 16'hFFFF);
      run_op("div_by_zero", 32'd1234, 16'd0);
      run_op("hi_eq_divisor", 32'h00010000, 16'd1);
      run_op("hi_just_below", 32'h000AFFFF, 16'd11);
      run_op("zero_dividend", 32'd0, 16'd7);

      for (int i = 0; i < 6; i++) begin
         rb = 16'($urandom_range(1, 65535));
         rh = 16'($urandom_range(0, 32'(rb) - 1));
         run_op("random", {rh, 16'($urandom)}, rb);
      end

      // Leave a nonzero result on the outputs, then reset in the middle of DIV.
      run_op("pre_reset", 32'd143, 16'd11);
      St = 1'b1;
      Dividendo = 32'd8006001;
      Divisor = 16'd4001;
      @(posedge Clk); #1;
      St = 1'b0;
      repeat (9) @(posedge Clk);
      #2 Rst = 1'b0;
      #1;
      check("midrst idle", 32'(Idle), 32'd1);
      check("midrst done", 32'(Done), 32'd0);
      check("midrst quociente", 32'(Quociente), 32'd0);
      check("midrst resto", 32'(Resto), 32'd0);
      check("midrst ovf", 32'(Ovf), 32'd0);
      @(posedge Clk); #3 Rst = 1'b1;
      dcount = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge Clk); #1;
         if (Done === 1'b1) dcount++;
      end
      check("midrst no_done", dcount, 0);
      check("midrst idle_after", 32'(Idle), 32'd1);

      // St held high for 40 cycles: operations chain back to back.
      e143 = model(32'd143, 16'd11);
      St = 1'b1;
      Dividendo = 32'd143;
      Divisor = 16'd11;
      pulses = 0;
      first_idx = 0;
      second_idx = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge Clk); #1;
         if (Done === 1'b1) begin
            pulses++;
            if (pulses == 1) first_idx = i;
            if (pulses == 2) second_idx = i;
            check("held quociente", 32'(Quociente), 32'(e143.q));
         end
      end
      St = 1'b0;
      check("held pulses", pulses, 2);
      check("held first_latency", first_idx, 19);
      check("held spacing", second_idx - first_idx, 19);
      // A third operation was started before St dropped; let it finish.
      seen3 = 1'b0;
      for (int i = 0; i < 40 && !seen3; i++) begin
         @(posedge Clk); #1;
         if (Done === 1'b1) seen3 = 1'b1;
      end
      check("held third_done", 32'(seen3), 32'd1);
      @(posedge Clk); #1;
      check("held idle_end", 32'(Idle), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
